// File: rtl/writeback_unit.sv
// Writeback stage: retires ALU results immediately and parks on a pending load
// until memory returns data, then extracts, extends and writes the loaded value.
module writeback_unit #(
  parameter int REGISTER_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ex_valid,
  output logic                      ex_ready,
  input  logic [4:0]                ex_rd_idx,
  input  logic [REGISTER_WIDTH-1:0] ex_result,
  input  logic                      ex_is_load,
  input  logic [2:0]                ex_funct3,
  input  logic [1:0]                ex_addr_lo,
  input  logic                      mem_rvalid,
  input  logic [REGISTER_WIDTH-1:0] mem_rdata,
  output logic [4:0]                rd_idx,
  output logic [REGISTER_WIDTH-1:0] data_in,
  output logic                      write_en,
  output logic                      byp_valid,
  output logic [4:0]                byp_idx,
  output logic [REGISTER_WIDTH-1:0] byp_data,
  output logic                      load_err,
  output logic [63:0]               retired
);

  typedef enum logic {IDLE, WAIT_LOAD} state_t;

  state_t                      state, state_nxt;
  logic [4:0]                  ld_rd_p0;
  logic [2:0]                  ld_f3_p0;
  logic [1:0]                  ld_addr_p0;
  logic                        cap;
  logic                        commit;
  logic                        err_nxt;
  logic [4:0]                  commit_rd;
  logic [REGISTER_WIDTH-1:0]   commit_data;

  // Misaligned halves/words and unassigned funct3 codes are faults.
  function automatic logic load_fault(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      3'b000, 3'b100: return 1'b0;
      3'b001, 3'b101: return a[0];
      3'b010:         return (a != 2'b00);
      default:        return 1'b1;
    endcase
  endfunction

  function automatic logic [REGISTER_WIDTH-1:0] extract_load(input logic [2:0] f3,
                                                             input logic [1:0] a,
                                                             input logic [REGISTER_WIDTH-1:0] word);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = word[{a, 3'b000} +: 8];
    h = word[{a[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  return {{(REGISTER_WIDTH-8){b[7]}}, b};
      3'b100:  return {{(REGISTER_WIDTH-8){1'b0}}, b};
      3'b001:  return {{(REGISTER_WIDTH-16){h[15]}}, h};
      3'b101:  return {{(REGISTER_WIDTH-16){1'b0}}, h};
      default: return word;
    endcase
  endfunction

  always_comb begin
    state_nxt   = state;
    ex_ready    = (state == IDLE) && !rst;
    cap         = 1'b0;
    commit      = 1'b0;
    err_nxt     = 1'b0;
    commit_rd   = ex_rd_idx;
    commit_data = ex_result;
    case (state)
      IDLE: begin
        // A data beat with no load outstanding is reported but never written.
        err_nxt = mem_rvalid;
        if (ex_valid) begin
          if (ex_is_load) begin
            cap       = 1'b1;
            state_nxt = WAIT_LOAD;
          end else begin
            commit = 1'b1;
          end
        end
      end
      WAIT_LOAD: begin
        if (mem_rvalid) begin
          state_nxt   = IDLE;
          commit_rd   = ld_rd_p0;
          commit_data = extract_load(ld_f3_p0, ld_addr_p0, mem_rdata);
          if (load_fault(ld_f3_p0, ld_addr_p0)) err_nxt = 1'b1;
          else                                  commit  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // p0: pending-load descriptor, only meaningful while in WAIT_LOAD
  always_ff @(posedge clk) begin
    if (cap) begin
      ld_rd_p0   <= ex_rd_idx;
      ld_f3_p0   <= ex_funct3;
      ld_addr_p0 <= ex_addr_lo;
    end
  end

  // p1: register-file write port, error pulse and retire counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      write_en <= 1'b0;
      rd_idx   <= 5'd0;
      data_in  <= '0;
      load_err <= 1'b0;
      retired  <= 64'd0;
    end else begin
      state    <= state_nxt;
      load_err <= err_nxt;
      write_en <= commit && (commit_rd != 5'd0);
      if (commit && (commit_rd != 5'd0)) begin
        rd_idx  <= commit_rd;
        data_in <= commit_data;
      end
      if (commit) retired <= retired + 64'd1;
    end
  end

  assign byp_valid = write_en;
  assign byp_idx   = rd_idx;
  assign byp_data  = data_in;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: a transaction-level model checked every
// cycle, plus literal expectations for the key scenarios.
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [4:0]  ex_rd_idx = 5'd0;
  logic [31:0] ex_result = 32'd0;
  logic        ex_is_load = 1'b0;
  logic [2:0]  ex_funct3 = 3'd0;
  logic [1:0]  ex_addr_lo = 2'd0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic [4:0]  rd_idx;
  logic [31:0] data_in;
  logic        write_en;
  logic        byp_valid;
  logic [4:0]  byp_idx;
  logic [31:0] byp_data;
  logic        load_err;
  logic [63:0] retired;

  writeback_unit #(.REGISTER_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_rd_idx(ex_rd_idx), .ex_result(ex_result), .ex_is_load(ex_is_load),
    .ex_funct3(ex_funct3), .ex_addr_lo(ex_addr_lo), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .rd_idx(rd_idx), .data_in(data_in), .write_en(write_en),
    .byp_valid(byp_valid), .byp_idx(byp_idx), .byp_data(byp_data),
    .load_err(load_err), .retired(retired)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic cmp_en = 1'b0;
  logic preload_req = 1'b0;

  // Literal expectations posted by the stimulus for one negedge.
  logic        lit_on = 1'b0;
  logic        lit_we, lit_err, lit_rdy;
  logic [4:0]  lit_rd;
  logic [31:0] lit_data;
  logic [63:0] lit_ret;

  // Model state
  logic        m_busy = 1'b0;
  logic [4:0]  m_ld_rd = 5'd0;
  logic [2:0]  m_ld_f3 = 3'd0;
  logic [1:0]  m_ld_a = 2'd0;
  logic        m_we = 1'b0;
  logic        m_err = 1'b0;
  logic [4:0]  m_rd = 5'd0;
  logic [31:0] m_data = 32'd0;
  logic [63:0] m_ret = 64'd0;

  function automatic int acc_size(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic bit load_ok(input logic [2:0] f3, input logic [1:0] a);
    int sz;
    sz = acc_size(f3);
    if (sz == 0) return 1'b0;
    return (int'(a) % sz) == 0;
  endfunction

  function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] w);
    int sz;
    logic [31:0] v;
    sz = acc_size(f3);
    v = w >> (8 * int'(a));
    if (sz < 4) begin
      v = v & ((32'd1 << (8 * sz)) - 32'd1);
      if (!f3[2] && v >= (32'd1 << (8 * sz - 1))) v = v - (32'd1 << (8 * sz));
    end
    return v;
  endfunction

  task automatic m_retire(input logic [4:0] rd, input logic [31:0] val);
    m_ret = m_ret + 64'd1;
    if (rd != 5'd0) begin
      m_we = 1'b1;
      m_rd = rd;
      m_data = val;
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 1'b0; m_we = 1'b0; m_err = 1'b0;
      m_rd = 5'd0; m_data = 32'd0; m_ret = 64'd0;
    end else begin
      if (preload_req) m_ret = '1;
      m_we = 1'b0;
      m_err = 1'b0;
      if (!m_busy) begin
        if (mem_rvalid) m_err = 1'b1;
        if (ex_valid) begin
          if (ex_is_load) begin
            m_busy = 1'b1; m_ld_rd = ex_rd_idx; m_ld_f3 = ex_funct3; m_ld_a = ex_addr_lo;
          end else begin
            m_retire(ex_rd_idx, ex_result);
          end
        end
      end else if (mem_rvalid) begin
        m_busy = 1'b0;
        if (load_ok(m_ld_f3, m_ld_a)) m_retire(m_ld_rd, load_val(m_ld_f3, m_ld_a, mem_rdata));
        else m_err = 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h, want %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("ex_ready",  64'(ex_ready),  64'(!rst && !m_busy));
      chk("write_en",  64'(write_en),  64'(m_we));
      chk("rd_idx",    64'(rd_idx),    64'(m_rd));
      chk("data_in",   64'(data_in),   64'(m_data));
      chk("byp_valid", 64'(byp_valid), 64'(m_we));
      chk("byp_idx",   64'(byp_idx),   64'(m_rd));
      chk("byp_data",  64'(byp_data),  64'(m_data));
      chk("load_err",  64'(load_err),  64'(m_err));
      chk("retired",   retired,        m_ret);
      if (lit_on) begin
        chk("lit_write_en", 64'(write_en), 64'(lit_we));
        chk("lit_rd_idx",   64'(rd_idx),   64'(lit_rd));
        chk("lit_data_in",  64'(data_in),  64'(lit_data));
        chk("lit_load_err", 64'(load_err), 64'(lit_err));
        chk("lit_retired",  retired,       lit_ret);
        chk("lit_ex_ready", 64'(ex_ready), 64'(lit_rdy));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_lit(input logic we, input logic [4:0] rd, input logic [31:0] data,
                            input logic err, input logic [63:0] ret, input logic rdy);
    lit_we = we; lit_rd = rd; lit_data = data; lit_err = err; lit_ret = ret; lit_rdy = rdy;
    lit_on = 1'b1;
    @(negedge clk);
    #1;
    lit_on = 1'b0;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] val);
    ex_valid = 1'b1; ex_is_load = 1'b0; ex_rd_idx = rd; ex_result = val;
    step();
    ex_valid = 1'b0;
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [1:0] a, input logic [4:0] rd,
                         input logic [31:0] word, input int waitc);
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_funct3 = f3; ex_addr_lo = a; ex_rd_idx = rd;
    step();
    ex_valid = 1'b0; ex_is_load = 1'b0;
    repeat (waitc) step();
    mem_rvalid = 1'b1; mem_rdata = word;
    step();
    mem_rvalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running, want finished");
    $fatal(1);
  end

  initial begin
    repeat (2) step();
    cmp_en = 1'b1;
    expect_lit(0, 5'd0, 32'd0, 0, 64'd0, 0);
    step();
    rst = 1'b0;
    expect_lit(0, 5'd0, 32'd0, 0, 64'd0, 1);

    alu(5'd5, 32'h1234_5678);
    expect_lit(1, 5'd5, 32'h1234_5678, 0, 64'd1, 1);

    // LB byte 3 with a 4-cycle wait; an ALU offer while waiting is ignored
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_funct3 = 3'b000; ex_addr_lo = 2'd3; ex_rd_idx = 5'd7;
    step();
    ex_is_load = 1'b0; ex_rd_idx = 5'd6; ex_result = 32'hDEAD_BEEF;
    expect_lit(0, 5'd5, 32'h1234_5678, 0, 64'd1, 0);
    repeat (3) step();
    ex_valid = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h80FF_0011;
    step();
    mem_rvalid = 1'b0;
    expect_lit(1, 5'd7, 32'hFFFF_FF80, 0, 64'd2, 1);

    do_load(3'b101, 2'd2, 5'd9, 32'hBEEF_0000, 0);
    expect_lit(1, 5'd9, 32'h0000_BEEF, 0, 64'd3, 1);
    do_load(3'b010, 2'd1, 5'd10, 32'h1111_2222, 1);
    expect_lit(0, 5'd9, 32'h0000_BEEF, 1, 64'd3, 1);
    step();
    expect_lit(0, 5'd9, 32'h0000_BEEF, 0, 64'd3, 1);
    do_load(3'b001, 2'd0, 5'd11, 32'h1234_8001, 2);
    expect_lit(1, 5'd11, 32'hFFFF_8001, 0, 64'd4, 1);
    do_load(3'b100, 2'd1, 5'd12, 32'h0000_AB00, 0);
    expect_lit(1, 5'd12, 32'h0000_00AB, 0, 64'd5, 1);
    do_load(3'b000, 2'd0, 5'd13, 32'h5555_557F, 0);
    expect_lit(1, 5'd13, 32'h0000_007F, 0, 64'd6, 1);
    do_load(3'b010, 2'd0, 5'd14, 32'hCAFE_F00D, 0);
    expect_lit(1, 5'd14, 32'hCAFE_F00D, 0, 64'd7, 1);
    do_load(3'b001, 2'd3, 5'd15, 32'h1234_5678, 0);
    expect_lit(0, 5'd14, 32'hCAFE_F00D, 1, 64'd7, 1);
    do_load(3'b111, 2'd0, 5'd16, 32'h1234_5678, 0);
    expect_lit(0, 5'd14, 32'hCAFE_F00D, 1, 64'd7, 1);
    do_load(3'b010, 2'd0, 5'd0, 32'h0000_0099, 0);
    expect_lit(0, 5'd14, 32'hCAFE_F00D, 0, 64'd8, 1);

    alu(5'd0, 32'h0000_FFFF);
    expect_lit(0, 5'd14, 32'hCAFE_F00D, 0, 64'd9, 1);

    // Spurious data beat coinciding with an ALU write, then a lone one
    mem_rvalid = 1'b1;
    alu(5'd20, 32'hA5A5_5A5A);
    mem_rvalid = 1'b0;
    expect_lit(1, 5'd20, 32'hA5A5_5A5A, 1, 64'd10, 1);
    mem_rvalid = 1'b1;
    step();
    mem_rvalid = 1'b0;
    expect_lit(0, 5'd20, 32'hA5A5_5A5A, 1, 64'd10, 1);

    // Reset while a load is outstanding, data arrives right after release
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_funct3 = 3'b010; ex_addr_lo = 2'd0; ex_rd_idx = 5'd21;
    step();
    ex_valid = 1'b0; ex_is_load = 1'b0;
    expect_lit(0, 5'd20, 32'hA5A5_5A5A, 0, 64'd10, 0);
    rst = 1'b1;
    step();
    expect_lit(0, 5'd0, 32'd0, 0, 64'd0, 0);
    rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
    step();
    mem_rvalid = 1'b0;
    expect_lit(0, 5'd0, 32'd0, 1, 64'd0, 1);
    step();
    expect_lit(0, 5'd0, 32'd0, 0, 64'd0, 1);

    // Retire counter wrap
    force dut.retired = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.retired;
    preload_req = 1'b1;
    step();
    preload_req = 1'b0;
    expect_lit(0, 5'd0, 32'd0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    alu(5'd3, 32'h0000_0077);
    expect_lit(1, 5'd3, 32'h0000_0077, 0, 64'd0, 1);

    // Reset wins over a simultaneous handshake and data beat
    rst = 1'b1; ex_valid = 1'b1; ex_is_load = 1'b0; ex_rd_idx = 5'd4; mem_rvalid = 1'b1;
    step();
    ex_valid = 1'b0; mem_rvalid = 1'b0;
    expect_lit(0, 5'd0, 32'd0, 0, 64'd0, 0);
    rst = 1'b0;
    step();
    expect_lit(0, 5'd0, 32'd0, 0, 64'd0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 SHALL have parameter REGISTER_WIDTH, default 32, datapath width; only 32 is supported.
REQ-002 SHALL use one clock and a reset that is synchronous and active-high.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port ex_valid, input, 1, execute stage presents a result.
REQ-006 SHALL have port ex_ready, output, 1, unit accepts an execute result this cycle.
REQ-007 SHALL have port ex_rd_idx, input, 5, destination register.
REQ-008 SHALL have port ex_result, input, 32, ALU result; ignored for loads.
REQ-009 SHALL have port ex_is_load, input, 1, the result is a pending load.
REQ-010 SHALL have port ex_funct3, input, 3, load type.
REQ-011 SHALL have port ex_addr_lo, input, 2, load address bits [1:0].
REQ-012 SHALL have port mem_rvalid, input, 1, load data valid, single-cycle pulse.
REQ-013 SHALL have port mem_rdata, input, 32, aligned memory word.
REQ-014 SHALL have ports rd_idx (output, 5), data_in (output, 32) and write_en (output, 1), which drive the register-file write port.
REQ-015 SHALL have port byp_valid, output, 1, with byp_idx (5) and byp_data (32), forming the forwarding copy of the write port.
REQ-016 SHALL have port load_err, output, 1, one-cycle pulse on a faulty load.
REQ-017 SHALL have port retired, output, 64, count of retired instructions.

Function
REQ-018 SHALL implement FSM states IDLE and WAIT_LOAD.
REQ-019 In IDLE, ex_ready SHALL be 1; in WAIT_LOAD, ex_ready SHALL be 0.
REQ-020 An ALU handshake (IDLE, ex_valid, !ex_is_load) SHALL register rd_idx=ex_rd_idx and data_in=ex_result, and SHALL assert write_en for exactly the next cycle; latency is 1 and the FSM stays in IDLE.
REQ-021 A load handshake (IDLE, ex_valid, ex_is_load) SHALL capture rd, funct3 and addr_lo and move to WAIT_LOAD; write_en SHALL be 0 the next cycle.
REQ-022 In WAIT_LOAD, mem_rvalid SHALL cause extraction and a return to IDLE; write_en SHALL assert in the following cycle.
REQ-023 In WAIT_LOAD, the FSM SHALL wait indefinitely without mem_rvalid; there is no timeout.
REQ-024 Extraction SHALL be: LB(000) sign-extends byte addr_lo; LBU(100) zero-extends byte addr_lo; LH(001) sign-extends half addr_lo[1]; LHU(101) zero-extends half addr_lo[1]; LW(010) passes the full word.
REQ-025 Byte k SHALL be mem_rdata[8k+7:8k], and half h SHALL be mem_rdata[16h+15:16h].
REQ-026 Error loads SHALL cause no write, no retire, and a load_err pulse coincident with the would-be write cycle; these are funct3 values 011, 110 or 111, LH/LHU with addr_lo[0]=1, and LW with addr_lo!=00.
REQ-027 When rd=0, write_en SHALL stay 0, but the instruction SHALL still retire.
REQ-028 retired SHALL increment by 1 in the write cycle of every non-error instruction and SHALL wrap from 2^64-1 to 0.
REQ-029 byp_valid, byp_idx and byp_data SHALL equal write_en, rd_idx and data_in in the same cycle.
REQ-030 When write_en=0, data_in and rd_idx SHALL hold their last values.
REQ-031 A mem_rvalid in IDLE SHALL be ignored and SHALL pulse load_err for one cycle the next cycle, with no write.
REQ-032 If a spurious mem_rvalid and an ALU write fall in the same cycle, the ALU write SHALL proceed unaffected.
REQ-033 ex_valid while ex_ready=0 SHALL be ignored, with no capture.

Reset
REQ-034 While rst=1, the unit SHALL hold state=IDLE, write_en=0, byp_valid=0, rd_idx=0, data_in=0, load_err=0 and retired=0; ex_ready SHALL be 0 during reset and 1 in the first cycle after.
REQ-035 A reset in WAIT_LOAD SHALL abandon the load, with no write and no error.
REQ-036 A mem_rvalid in the first cycle after reset SHALL be treated per REQ-031.
REQ-037 rst SHALL take priority over every other input in the same cycle.

Verification
REQ-038 The bench SHALL cover: ALU result 0x1234_5678 to rd=5 -> next cycle write_en=1, rd_idx=5, data_in=0x1234_5678, byp mirrors it, retired=1.
REQ-039 The bench SHALL cover: LB, addr_lo=3, mem_rdata=0x80FF_0011 after a 4-cycle wait -> ex_ready=0 while waiting, then write of 0xFFFF_FF80.
REQ-040 The bench SHALL cover: LHU, addr_lo=2, mem_rdata=0xBEEF_0000 -> data_in=0x0000_BEEF; and LW, addr_lo=01 -> load_err pulse, write_en=0, retired unchanged.
REQ-041 The bench SHALL cover: ALU write to rd=0 -> write_en=0, retired increments.
REQ-042 The bench SHALL cover: rst asserted in WAIT_LOAD, then mem_rvalid one cycle after release -> no write, load_err=1 for one cycle, retired=0.
REQ-043 The bench SHALL cover: retired preloaded via 2^64-1 retires (forced) plus one ALU retire -> retired=0.
